// File: rtl/alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_arbiter : two-requester round-robin share of one alu32, with a       |
// |               single-entry tagged response register.                     |
// | Optional feature macro: ALU_ARB_LOCK_EN (per-requester priority lock).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module alu32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_ctrl,
  output logic [31:0] o_out,
  output logic        o_zero,
  output logic        o_negative,
  output logic        o_overflow
);
  logic [31:0] w_sum;
  logic [31:0] w_diff;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;

  always_comb begin
    o_out      = '0;
    o_overflow = 1'b0;
    case (i_ctrl)
      3'd2: begin
        o_out      = w_sum;
        o_overflow = (i_a[31] == i_b[31]) & (w_sum[31] != i_a[31]);
      end
      3'd3: begin
        o_out      = w_diff;
        o_overflow = (i_a[31] != i_b[31]) & (w_diff[31] != i_a[31]);
      end
      3'd4:    o_out = i_a & i_b;
      3'd5:    o_out = i_a | i_b;
      3'd6:    o_out = ~(i_a | i_b);
      3'd7:    o_out = i_a ^ i_b;
      default: o_out = '0;
    endcase
  end

  assign o_zero     = (o_out == 32'd0);
  assign o_negative = o_out[31];
endmodule

module alu_arbiter #(
  parameter int unsigned FIRST_PRI = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
`ifdef ALU_ARB_LOCK_EN
  input  logic        req0_lock,
  input  logic        req1_lock,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_out,
  output logic        rsp_zero,
  output logic        rsp_negative,
  output logic        rsp_overflow
);
  localparam logic c_first_pri = (FIRST_PRI != 0);

  logic        r_pri;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [31:0] r_rsp_out;
  logic        r_rsp_zero;
  logic        r_rsp_negative;
  logic        r_rsp_overflow;

  logic        w_can_accept;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_xfer;
  logic        w_sel;
  logic        w_next_pri;
  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [2:0]  w_alu_op;
  logic [31:0] w_alu_out;
  logic        w_alu_zero;
  logic        w_alu_negative;
  logic        w_alu_overflow;

  // r_pri names the requester that wins when both are valid.
  assign w_can_accept = ~r_rsp_valid | rsp_ready;
  assign w_gnt0       = req0_valid & (~req1_valid | ~r_pri);
  assign w_gnt1       = req1_valid & (~req0_valid |  r_pri);
  assign req0_ready   = w_gnt0 & w_can_accept & reset_n;
  assign req1_ready   = w_gnt1 & w_can_accept & reset_n;
  assign w_xfer       = req0_ready | req1_ready;
  assign w_sel        = w_gnt1;

  assign w_alu_a  = w_sel ? req1_a  : req0_a;
  assign w_alu_b  = w_sel ? req1_b  : req0_b;
  assign w_alu_op = w_sel ? req1_op : req0_op;

`ifdef ALU_ARB_LOCK_EN
  // A locked transfer keeps priority with the same requester for its next op.
  assign w_next_pri = (w_sel ? req1_lock : req0_lock) ? w_sel : ~w_sel;
`else
  assign w_next_pri = ~w_sel;
`endif

  alu32 u_alu (
    .i_a        (w_alu_a),
    .i_b        (w_alu_b),
    .i_ctrl     (w_alu_op),
    .o_out      (w_alu_out),
    .o_zero     (w_alu_zero),
    .o_negative (w_alu_negative),
    .o_overflow (w_alu_overflow)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pri          <= c_first_pri;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= 1'b0;
      r_rsp_out      <= '0;
      r_rsp_zero     <= 1'b0;
      r_rsp_negative <= 1'b0;
      r_rsp_overflow <= 1'b0;
    end else if (w_xfer) begin
      r_pri          <= w_next_pri;
      r_rsp_valid    <= 1'b1;
      r_rsp_id       <= w_sel;
      r_rsp_out      <= w_alu_out;
      r_rsp_zero     <= w_alu_zero;
      r_rsp_negative <= w_alu_negative;
      r_rsp_overflow <= w_alu_overflow;
    end else if (rsp_ready) begin
      r_rsp_valid    <= 1'b0;
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_out      = r_rsp_out;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_negative = r_rsp_negative;
  assign rsp_overflow = r_rsp_overflow;
endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_arbiter : vector table plus scoreboard bench for alu_arbiter.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_alu_arbiter;
  localparam int unsigned FP = 0;

  logic        clk;
  logic        reset_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_out;
  logic        rsp_zero, rsp_negative, rsp_overflow;
`ifdef ALU_ARB_LOCK_EN
  logic        req0_lock, req1_lock;
`endif

  int checks = 0;
  int failures = 0;

  alu_arbiter #(.FIRST_PRI(FP)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_op      (req0_op),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_op      (req1_op),
`ifdef ALU_ARB_LOCK_EN
    .req0_lock    (req0_lock),
    .req1_lock    (req1_lock),
`endif
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_out      (rsp_out),
    .rsp_zero     (rsp_zero),
    .rsp_negative (rsp_negative),
    .rsp_overflow (rsp_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        id;
    logic [31:0] out;
    logic        z;
    logic        n;
    logic        o;
  } rsp_t;

  typedef struct packed {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] out;
    logic        z;
    logic        n;
    logic        o;
  } vec_t;

  function automatic rsp_t ref_alu(input logic id, input logic [31:0] a,
                                   input logic [31:0] b, input logic [2:0] op);
    rsp_t r;
    r.id = id;
    r.o  = 1'b0;
    case (op)
      3'd2: begin r.out = a + b; r.o = (a[31] == b[31]) && (r.out[31] != a[31]); end
      3'd3: begin r.out = a - b; r.o = (a[31] != b[31]) && (r.out[31] != a[31]); end
      3'd4: r.out = a & b;
      3'd5: r.out = a | b;
      3'd6: r.out = ~(a | b);
      3'd7: r.out = a ^ b;
      default: r.out = 32'd0;
    endcase
    r.z = (r.out == 32'd0);
    r.n = r.out[31];
    return r;
  endfunction

  // Scoreboard: reference arbiter state, updated once per cycle at negedge.
  rsp_t sb[$];
  logic m_valid = 1'b0;
  logic m_pri   = FP[0];
  logic m_can, m_e0, m_e1, m_lock;
  rsp_t got, exp_r;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      sb.delete();
      m_valid = 1'b0;
      m_pri   = FP[0];
    end else begin
      m_can = !m_valid || rsp_ready;
      m_e0  = m_can && req0_valid && (!req1_valid || !m_pri);
      m_e1  = m_can && req1_valid && (!req0_valid ||  m_pri);
      chk("sb_req0_ready", req0_ready, m_e0);
      chk("sb_req1_ready", req1_ready, m_e1);
      chk("sb_rsp_valid", rsp_valid, m_valid);
      if (m_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_underflow: got response with empty queue at %0t", $time);
        end else begin
          exp_r = sb.pop_front();
          got   = '{rsp_id, rsp_out, rsp_zero, rsp_negative, rsp_overflow};
          chk("sb_rsp", got, exp_r);
        end
      end
      m_lock = 1'b0;
`ifdef ALU_ARB_LOCK_EN
      m_lock = m_e0 ? req0_lock : req1_lock;
`endif
      if (m_e0 || m_e1) begin
        if (m_e0) sb.push_back(ref_alu(1'b0, req0_a, req0_b, req0_op));
        else      sb.push_back(ref_alu(1'b1, req1_a, req1_b, req1_op));
        m_pri   = m_lock ? m_e1 : !m_e1;
        m_valid = 1'b1;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd5,        32'd7,        3'd2, 32'd12,       1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h7FFFFFFF, 32'd1,        3'd2, 32'h80000000, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 32'd3,        32'd3,        3'd3, 32'd0,        1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'hF0,       32'h0F,       3'd5, 32'hFF,       1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 32'h1234,     32'h5678,     3'd0, 32'd0,        1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd1, 32'd0,        1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 3'd4, 32'h0F000F00, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'd0,        32'd0,        3'd6, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 32'hAAAAAAAA, 32'hAAAAAAAA, 3'd7, 32'd0,        1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h80000000, 32'd1,        3'd3, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 32'h80000000, 32'h80000000, 3'd4, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 32'd0,        32'd1,        3'd3, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};

    reset_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
`ifdef ALU_ARB_LOCK_EN
    req0_lock = 1'b0; req1_lock = 1'b0;
`endif
    repeat (2) tick();
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_out", rsp_out, 0);
    chk("reset_rsp_flags", {rsp_zero, rsp_negative, rsp_overflow}, 0);
    reset_n = 1'b1;

    // Single-requester vectors, one per cycle.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].id) begin
        req1_valid = 1'b1; req1_a = vecs[i].a; req1_b = vecs[i].b; req1_op = vecs[i].op;
      end else begin
        req0_valid = 1'b1; req0_a = vecs[i].a; req0_b = vecs[i].b; req0_op = vecs[i].op;
      end
      #1;
      chk("vec_ready", vecs[i].id ? req1_ready : req0_ready, 1);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("vec_rsp_valid", rsp_valid, 1);
      chk("vec_rsp_id", rsp_id, vecs[i].id);
      chk("vec_rsp_out", rsp_out, vecs[i].out);
      chk("vec_rsp_flags", {rsp_zero, rsp_negative, rsp_overflow},
          {vecs[i].z, vecs[i].n, vecs[i].o});
    end
    tick();
    chk("drain_empty", rsp_valid, 0);
    tick();
    chk("ready_while_empty", rsp_valid, 0);

    // Fairness with both requesters continuously valid.
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd3;  req0_b = 32'd3;  req0_op = 3'd3;
    req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 3'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_id", rsp_id, i % 2);
      chk("rr_out", rsp_out, (i % 2) ? 32'hFF : 32'd0);
    end

    // Back-pressure: response frozen, no readies.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_readies", {req0_ready, req1_ready}, 0);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_id", rsp_id, 1);
      chk("hold_out", rsp_out, 32'hFF);
    end
    rsp_ready = 1'b1;
    #1;
    chk("release_req0_ready", req0_ready, 1);
    tick();
    chk("release_valid", rsp_valid, 1);
    chk("release_id", rsp_id, 0);
    chk("release_out", {rsp_out, rsp_zero}, {32'd0, 1'b1});

    // Reset while full with both requesters valid.
    reset_n = 1'b0;
    tick();
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_out", {rsp_id, rsp_out, rsp_zero, rsp_negative, rsp_overflow}, 0);
    reset_n = 1'b1;
    #1;
    chk("midrst_pri_r0", req0_ready, 1);
    chk("midrst_pri_r1", req1_ready, 0);
    tick();
    chk("midrst_first_id", rsp_id, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

`ifdef ALU_ARB_LOCK_EN
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    req0_valid = 1'b1; req0_lock = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lock_id", rsp_id, 0);
    end
    req0_lock = 1'b0;
    tick();
    chk("unlock_id0", rsp_id, 0);
    tick();
    chk("unlock_id1", rsp_id, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
`endif

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
